exercicio3_sweep_ctrl: RTL and testbench

Sequencer that exhaustively exercises the 4-input logic function f = a | b | (~c & d).
- Drives all 16 {a,b,c,d} combinations in ascending order and waits a programmable settle time for each one.
- Samples f into a 16-bit truth-table register and compares it bit-by-bit against an expected table.
- Used as a self-checking on-chip/bench controller in place of hand-written stimulus sequences; reports busy/done/pass plus failure diagnostics.

---
 rtl/exercicio3_pkg.sv | 26 ++
 rtl/exercicio3_sweep_cnt.sv | 40 ++++
 rtl/exercicio3_sweep_ctrl.sv | 120 ++++++++++++
 tb/tb_exercicio3_sweep_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/exercicio3_pkg.sv
// Shared types and constants for the truth-table sweep controller.
// Holds the FSM encoding, table size, default expected table and a settle clamp.
package exercicio3_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int          N_COMB      = 16;
    localparam int          IDX_W       = 4;
    localparam logic [15:0] EXP_F_TABLE = 16'hFFF2;

    // Out-of-range settle values fold into the 1..15 range the counter supports.
    function automatic logic [3:0] settle_clamp(input int s);
        if (s < 1)
            return 4'd1;
        else if (s > 15)
            return 4'd15;
        else
            return 4'(s);
    endfunction

endpackage

// File: rtl/exercicio3_sweep_cnt.sv
// Purpose: combination index and per-combination settle countdown for the sweep.
// Latency: load/step/tick take effect on the next edge; flags are combinational from state.
// Backpressure: none; the controller decides when each command is issued.
module exercicio3_sweep_cnt
    import exercicio3_pkg::*;
#(
    parameter logic [3:0] SETTLE_LD = 4'd2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             tick,
    input  logic             step,
    output logic [IDX_W-1:0] idx,
    output logic [3:0]       settle_cnt,
    output logic             settled,
    output logic             last
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx        <= '0;
            settle_cnt <= '0;
        end else if (load) begin
            idx        <= '0;
            settle_cnt <= SETTLE_LD;
        end else if (step) begin
            // Index saturates at the last combination; the sweep ends there.
            if (!last)
                idx <= idx + 1'b1;
            settle_cnt <= SETTLE_LD;
        end else if (tick && settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 1'b1;
        end
    end

    assign settled = (settle_cnt <= 4'd1);
    assign last    = (idx == IDX_W'(N_COMB - 1));

endmodule

// File: rtl/exercicio3_sweep_ctrl.sv
// Purpose: drive all 16 {a,b,c,d} codes, sample f_i, compare against an expected table.
// Latency: 16*(SETTLE+1) cycles from accepted start to done.
// Backpressure: start ignored while busy; abort returns to IDLE on the next edge.
module exercicio3_sweep_ctrl
    import exercicio3_pkg::*;
#(
    parameter int          SETTLE      = 2,
    parameter logic [15:0] EXP_DEFAULT = EXP_F_TABLE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        use_ext_exp,
    input  logic [15:0] exp_table,
    output logic [3:0]  abcd_o,
    input  logic        f_i,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] table_o,
    output logic [4:0]  mismatch_cnt,
    output logic [3:0]  first_fail
);

    localparam logic [3:0] SETTLE_LD = settle_clamp(SETTLE);

    state_t            state_q;
    state_t            state_d;
    logic [15:0]       exp_q;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        settle_cnt;
    logic              settled;
    logic              last;
    logic              start_acc;
    logic              cnt_tick;
    logic              cnt_step;
    logic              sample_en;

    assign start_acc = start && !abort && (state_q == ST_IDLE || state_q == ST_DONE);
    assign sample_en = (state_q == ST_SAMPLE) && !abort;
    assign cnt_tick  = (state_q == ST_DRIVE) && !abort;
    assign cnt_step  = sample_en && !last;

    exercicio3_sweep_cnt #(
        .SETTLE_LD (SETTLE_LD)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (start_acc),
        .tick       (cnt_tick),
        .step       (cnt_step),
        .idx        (idx),
        .settle_cnt (settle_cnt),
        .settled    (settled),
        .last       (last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE,
                ST_DONE:   if (start) state_d = ST_DRIVE;
                ST_DRIVE:  if (settled) state_d = ST_SAMPLE;
                ST_SAMPLE: state_d = last ? ST_DONE : ST_DRIVE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        abcd_o = 4'd0;
        case (state_q)
            ST_DRIVE,
            ST_SAMPLE: begin
                busy   = 1'b1;
                abcd_o = idx;
            end
            ST_DONE:   done = 1'b1;
            default:   ;
        endcase
    end

    assign pass = done && (mismatch_cnt == 5'd0);

    // A zero count before this sample means this is the sweep's first mismatch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exp_q        <= '0;
            table_o      <= '0;
            mismatch_cnt <= '0;
            first_fail   <= '0;
        end else if (start_acc) begin
            exp_q        <= use_ext_exp ? exp_table : EXP_DEFAULT;
            table_o      <= '0;
            mismatch_cnt <= '0;
            first_fail   <= '0;
        end else if (sample_en) begin
            table_o[idx] <= f_i;
            if (f_i != exp_q[idx]) begin
                mismatch_cnt <= mismatch_cnt + 5'd1;
                if (mismatch_cnt == 5'd0)
                    first_fail <= idx;
            end
        end
    end

endmodule

// File: tb/tb_exercicio3_sweep_ctrl.sv
// Directed bench for the sweep controller: table-driven full sweeps plus abort,
// restart-while-busy, reset-during-done and short-settle corner sequences.
module tb_exercicio3_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic        abort;
    logic        use_ext_exp;
    logic [15:0] exp_table;
    logic        force0;
    logic [3:0]  abcd0;
    logic        f0;
    logic        busy0, done0, pass0;
    logic [15:0] table0;
    logic [4:0]  mm0;
    logic [3:0]  ff0;

    logic        start1;
    logic [3:0]  abcd1, abcd2;
    logic        f1, f2;
    logic        busy1, done1, pass1, busy2, done2, pass2;
    logic [15:0] table1, table2;
    logic [4:0]  mm1, mm2;
    logic [3:0]  ff1, ff2;

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic logic fn(input logic [3:0] v);
        return v[3] | v[2] | (~v[1] & v[0]);
    endfunction

    assign f0 = force0 ? 1'b0 : fn(abcd0);
    assign f1 = fn(abcd1);
    assign f2 = fn(abcd2);

    exercicio3_sweep_ctrl #(.SETTLE(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .use_ext_exp(use_ext_exp), .exp_table(exp_table),
        .abcd_o(abcd0), .f_i(f0), .busy(busy0), .done(done0), .pass(pass0),
        .table_o(table0), .mismatch_cnt(mm0), .first_fail(ff0)
    );

    exercicio3_sweep_ctrl #(.SETTLE(1)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0),
        .use_ext_exp(1'b0), .exp_table(16'h0000),
        .abcd_o(abcd1), .f_i(f1), .busy(busy1), .done(done1), .pass(pass1),
        .table_o(table1), .mismatch_cnt(mm1), .first_fail(ff1)
    );

    exercicio3_sweep_ctrl #(.SETTLE(0)) u_dut_s0 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0),
        .use_ext_exp(1'b0), .exp_table(16'h0000),
        .abcd_o(abcd2), .f_i(f2), .busy(busy2), .done(done2), .pass(pass2),
        .table_o(table2), .mismatch_cnt(mm2), .first_fail(ff2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulses start, then changes the table inputs to prove they were latched.
    task automatic run_sweep(input logic ue, input logic [15:0] et, input logic fz,
                             input int restart_at, output int cyc, output bit seq_ok);
        use_ext_exp = ue;
        exp_table   = et;
        force0      = fz;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        use_ext_exp = ~ue;
        exp_table   = ~et;
        cyc    = 0;
        seq_ok = 1'b1;
        while (done0 !== 1'b1 && cyc < 200) begin
            if (abcd0 !== 4'(cyc / 3) || busy0 !== 1'b1)
                seq_ok = 1'b0;
            start = (cyc == restart_at);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic        ue;
        logic [15:0] et;
        logic        fz;
        logic [15:0] x_tab;
        logic [4:0]  x_mm;
        logic [3:0]  x_ff;
        logic        x_pass;
    } vec_t;

    vec_t vecs[6];

    task automatic check_result(input vec_t v, input int cyc, input bit seq_ok);
        check({v.name, ".cycles"}, 32'(cyc), 32'd48);
        check({v.name, ".abcd_seq"}, 32'(seq_ok), 32'd1);
        check({v.name, ".table"}, 32'(table0), 32'(v.x_tab));
        check({v.name, ".mismatch"}, 32'(mm0), 32'(v.x_mm));
        check({v.name, ".first_fail"}, 32'(ff0), 32'(v.x_ff));
        check({v.name, ".pass"}, 32'(pass0), 32'(v.x_pass));
        check({v.name, ".done_busy_abcd"}, {26'd0, done0, busy0, abcd0}, {26'd0, 1'b1, 1'b0, 4'd0});
    endtask

    initial begin
        int  cyc;
        bit  seq_ok;
        int  c1, c2;

        vecs[0] = '{"dflt_ok",      1'b0, 16'h0000, 1'b0, 16'hFFF2, 5'd0,  4'd0,  1'b1};
        vecs[1] = '{"dflt_f0",      1'b0, 16'h0000, 1'b1, 16'h0000, 5'd13, 4'd1,  1'b0};
        vecs[2] = '{"ext_fff3",     1'b1, 16'hFFF3, 1'b0, 16'hFFF2, 5'd1,  4'd0,  1'b0};
        vecs[3] = '{"ext_zero",     1'b1, 16'h0000, 1'b0, 16'hFFF2, 5'd13, 4'd1,  1'b0};
        vecs[4] = '{"ext_7ff2",     1'b1, 16'h7FF2, 1'b0, 16'hFFF2, 5'd1,  4'd15, 1'b0};
        vecs[5] = '{"ext_zero_f0",  1'b1, 16'h0000, 1'b1, 16'h0000, 5'd0,  4'd0,  1'b1};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; use_ext_exp = 1'b0;
        exp_table = 16'h0000; force0 = 1'b0; start1 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.abcd", 32'(abcd0), 32'd0);
        check("rst.flags", {29'd0, busy0, done0, pass0}, 32'd0);
        check("rst.table", 32'(table0), 32'd0);
        check("rst.mm_ff", {23'd0, mm0, ff0}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_sweep(vecs[i].ue, vecs[i].et, vecs[i].fz, -1, cyc, seq_ok);
            check_result(vecs[i], cyc, seq_ok);
            repeat (2) @(negedge clk);
            check({vecs[i].name, ".done_hold"}, 32'(done0), 32'd1);
        end

        // Abort mid-sweep, then a clean sweep from IDLE.
        use_ext_exp = 1'b0; force0 = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort.flags", {29'd0, busy0, done0, pass0}, 32'd0);
        check("abort.abcd", 32'(abcd0), 32'd0);
        run_sweep(1'b0, 16'h0000, 1'b0, -1, cyc, seq_ok);
        check_result(vecs[0], cyc, seq_ok);

        // Abort wins over start while in DONE.
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_vs_start.flags", {29'd0, busy0, done0, pass0}, 32'd0);
        @(negedge clk);
        check("abort_vs_start.idle", 32'(busy0), 32'd0);

        // A second start while busy must not restart the sweep.
        run_sweep(1'b0, 16'h0000, 1'b0, 10, cyc, seq_ok);
        check_result(vecs[0], cyc, seq_ok);

        // Reset beats start in DONE.
        rst_n = 1'b0; start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;
        check("rst_done.flags", {29'd0, busy0, done0, pass0}, 32'd0);
        check("rst_done.table", 32'(table0), 32'd0);
        check("rst_done.mm_ff_abcd", {19'd0, mm0, ff0, abcd0}, 32'd0);
        repeat (3) @(negedge clk);
        check("rst_done.no_sweep", {30'd0, busy0, done0}, 32'd0);

        // Short settle: SETTLE=1 and SETTLE=0 (clamped to 1) both take 32 cycles.
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        cyc = 0; c1 = -1; c2 = -1;
        while (cyc < 200 && (c1 < 0 || c2 < 0)) begin
            if (done1 === 1'b1 && c1 < 0) c1 = cyc;
            if (done2 === 1'b1 && c2 < 0) c2 = cyc;
            @(negedge clk);
            cyc++;
        end
        check("s1.cycles", 32'(c1), 32'd32);
        check("s0.cycles", 32'(c2), 32'd32);
        check("s1.table", 32'(table1), 32'hFFF2);
        check("s1.pass_mm", {26'd0, pass1, mm1}, {26'd0, 1'b1, 5'd0});
        check("s0.table", 32'(table2), 32'hFFF2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
